// File: rtl/rs_latch_if.sv
// rtl/rs_latch_if.sv - set/reset request and latched-state bundle for rs_latch
interface rs_latch_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] n;
  logic [WIDTH-1:0] conflict;

  modport master (
    output s,
    output r,
    input  q,
    input  n,
    input  conflict
  );

  modport slave (
    input  s,
    input  r,
    output q,
    output n,
    output conflict
  );
endinterface

// File: rtl/rs_latch.sv
// rtl/rs_latch.sv - bank of clocked set/reset bits with selectable conflict policy
module rs_latch #(
  parameter int               WIDTH    = 1,
  parameter logic [WIDTH-1:0] RESET_Q  = '0,
  parameter int               CONFLICT = 0
) (
  input  logic      clk,
  input  logic      rst,
  rs_latch_if.slave bus
);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] conflict_reg;
  logic [WIDTH-1:0] both;

  always_comb begin
    both   = bus.s & bus.r;
    q_next = q_reg;
    for (int i = 0; i < WIDTH; i++) begin
      if (both[i]) begin
        // Policy codes outside 0..3 fall back to reset-dominant.
        case (CONFLICT)
          1:       q_next[i] = 1'b1;
          2:       q_next[i] = q_reg[i];
          3:       q_next[i] = ~q_reg[i];
          default: q_next[i] = 1'b0;
        endcase
      end else if (bus.s[i]) begin
        q_next[i] = 1'b1;
      end else if (bus.r[i]) begin
        q_next[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg        <= RESET_Q;
      conflict_reg <= '0;
    end else begin
      q_reg        <= q_next;
      conflict_reg <= both;
    end
  end

  // n comes from the same register so it can never equal q.
  assign bus.q        = q_reg;
  assign bus.n        = ~q_reg;
  assign bus.conflict = conflict_reg;

endmodule

// File: tb/tb_rs_latch.sv
// tb/tb_rs_latch.sv - directed self-checking bench for rs_latch
module tb_rs_latch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  rs_latch_if #(.WIDTH(1)) b0 ();
  rs_latch_if #(.WIDTH(1)) b1 ();
  rs_latch_if #(.WIDTH(1)) b2 ();
  rs_latch_if #(.WIDTH(1)) b3 ();
  rs_latch_if #(.WIDTH(4)) bw ();

  rs_latch #(.WIDTH(1), .RESET_Q(1'b0), .CONFLICT(0)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
  rs_latch #(.WIDTH(1), .RESET_Q(1'b0), .CONFLICT(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
  rs_latch #(.WIDTH(1), .RESET_Q(1'b0), .CONFLICT(2)) dut2 (.clk(clk), .rst(rst), .bus(b2.slave));
  rs_latch #(.WIDTH(1), .RESET_Q(1'b0), .CONFLICT(3)) dut3 (.clk(clk), .rst(rst), .bus(b3.slave));
  rs_latch #(.WIDTH(4), .RESET_Q(4'b1010), .CONFLICT(0)) dutw (.clk(clk), .rst(rst), .bus(bw.slave));

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive1(input logic s, input logic r);
    b0.s = s; b0.r = r;
    b1.s = s; b1.r = r;
    b2.s = s; b2.r = r;
    b3.s = s; b3.r = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_q1(input string tag, input logic e0, input logic e1,
                        input logic e2, input logic e3);
    chk({tag, "_q0"}, {3'b0, b0.q}, {3'b0, e0});
    chk({tag, "_q1"}, {3'b0, b1.q}, {3'b0, e1});
    chk({tag, "_q2"}, {3'b0, b2.q}, {3'b0, e2});
    chk({tag, "_q3"}, {3'b0, b3.q}, {3'b0, e3});
    chk({tag, "_n0"}, {3'b0, b0.n}, {3'b0, ~e0});
    chk({tag, "_n3"}, {3'b0, b3.n}, {3'b0, ~e3});
  endtask

  task automatic chk_c1(input string tag, input logic e);
    chk({tag, "_c0"}, {3'b0, b0.conflict}, {3'b0, e});
    chk({tag, "_c1"}, {3'b0, b1.conflict}, {3'b0, e});
    chk({tag, "_c2"}, {3'b0, b2.conflict}, {3'b0, e});
    chk({tag, "_c3"}, {3'b0, b3.conflict}, {3'b0, e});
  endtask

  initial begin
    // Reset wins over a pending set on every instance.
    rst = 1'b1;
    drive1(1'b1, 1'b0);
    bw.s = 4'b1111; bw.r = 4'b0000;
    step();
    chk_q1("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk_c1("rst", 1'b0);
    chk("rst_wq", bw.q, 4'b1010);
    chk("rst_wn", bw.n, 4'b0101);
    chk("rst_wc", bw.conflict, 4'b0000);

    rst = 1'b0;
    bw.s = 4'b0000;
    drive1(1'b0, 1'b1);
    step();
    chk_q1("clr0", 1'b0, 1'b0, 1'b0, 1'b0);

    drive1(1'b1, 1'b0);
    #1;
    chk("set_pre_q0", {3'b0, b0.q}, 4'b0000);
    step();
    chk_q1("set", 1'b1, 1'b1, 1'b1, 1'b1);
    chk_c1("set", 1'b0);

    drive1(1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk_q1("hold", 1'b1, 1'b1, 1'b1, 1'b1);
    end

    drive1(1'b0, 1'b1);
    #1;
    chk("clr_pre_q0", {3'b0, b0.q}, 4'b0001);
    step();
    chk_q1("clr", 1'b0, 1'b0, 1'b0, 1'b0);

    drive1(1'b1, 1'b0);
    step();
    step();
    chk_q1("reset_again", 1'b1, 1'b1, 1'b1, 1'b1);
    chk_c1("reset_again", 1'b0);

    // Two edges of simultaneous set and reset expose each policy.
    drive1(1'b1, 1'b1);
    step();
    chk_q1("cf1", 1'b0, 1'b1, 1'b1, 1'b0);
    chk_c1("cf1", 1'b1);
    step();
    chk_q1("cf2", 1'b0, 1'b1, 1'b1, 1'b1);
    chk_c1("cf2", 1'b1);
    drive1(1'b0, 1'b0);
    step();
    chk_q1("cf_end", 1'b0, 1'b1, 1'b1, 1'b1);
    chk_c1("cf_end", 1'b0);

    drive1(1'b0, 1'b1);
    step();
    step();
    chk_q1("reclr", 1'b0, 1'b0, 1'b0, 1'b0);
    chk_c1("reclr", 1'b0);
    drive1(1'b0, 1'b0);

    // Multi-bit independence on the wide instance.
    bw.s = 4'b0001; bw.r = 4'b1000;
    step();
    chk("w_sr_q", bw.q, 4'b0011);
    chk("w_sr_n", bw.n, 4'b1100);
    chk("w_sr_c", bw.conflict, 4'b0000);

    bw.s = 4'b0110; bw.r = 4'b0100;
    step();
    chk("w_cf_q", bw.q, 4'b0011);
    chk("w_cf_c", bw.conflict, 4'b0100);

    rst = 1'b1;
    bw.s = 4'b1111; bw.r = 4'b0000;
    step();
    chk("w_rst_q", bw.q, 4'b1010);
    chk("w_rst_n", bw.n, 4'b0101);
    chk("w_rst_c", bw.conflict, 4'b0000);
    rst = 1'b0;
    bw.s = 4'b0000;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
